// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencing controller for the 5-stage mini MIPS core.
// Drives the PC / IF/ID / ID/EX / EX/DM load enables and flushes from
// three hazard sources, highest priority first:
//   1. data-memory wait
//   2. taken-branch flush
//   3. load-use stall
// Also keeps saturating stall/flush counters and a sticky DM timeout error.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   id_rs_addr, id_rt_addr           source fields of the ID instruction
//   id_uses_rt                       ID instruction reads rt
//   id_ex_rd_out_addr, id_ex_rd_ctrl destination / is-load of the EX instruction
//   ex_branch_taken                  branch in EX resolved taken
//   ex_dm_rd_ctrl, ex_dm_wd_ctrl     DM-stage instruction reads / writes memory
//   dm_ready                         data memory completes the access this cycle
//   pc_en .. ex_dm_en, flushes       pipeline register controls (combinational)
//   wb_valid, dm_req                 writeback valid, memory request (combinational)
//   dm_err                           sticky timeout error (registered)
//   state                            0 RUN, 1 DM_WAIT, 2 HALT (registered)
//   stall_cnt, flush_cnt             saturating performance counters (registered)
module pipe_hazard_ctrl #(
    parameter int unsigned DM_TIMEOUT = 15,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_ex_rd_out_addr,
    input  logic             id_ex_rd_ctrl,
    input  logic             ex_branch_taken,
    input  logic             ex_dm_rd_ctrl,
    input  logic             ex_dm_wd_ctrl,
    input  logic             dm_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_dm_en,
    output logic             wb_valid,
    output logic             dm_req,
    output logic             dm_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = $clog2(DM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DM_WAIT = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t            state_q;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  flush_q;
    logic              err_q;

    logic dm_op;
    logic lu_hz;
    logic active;
    logic dm_stall;
    logic br_flush;
    logic lu_stall;

    // Hazard decode; each lower-priority condition is masked by the ones above it.
    always_comb begin
        dm_op    = ex_dm_rd_ctrl | ex_dm_wd_ctrl;
        lu_hz    = id_ex_rd_ctrl && (id_ex_rd_out_addr != 5'd0) &&
                   ((id_ex_rd_out_addr == id_rs_addr) ||
                    (id_uses_rt && (id_ex_rd_out_addr == id_rt_addr)));
        active   = !rst && (state_q != HALT);
        dm_stall = active && dm_op && !dm_ready;
        br_flush = active && !dm_stall && ex_branch_taken;
        lu_stall = active && !dm_stall && !ex_branch_taken && lu_hz;
    end

    // Pipeline controls act in the same cycle the condition is seen.
    always_comb begin
        pc_en       = active && !dm_stall && !lu_stall;
        if_id_en    = active && !dm_stall && !lu_stall;
        id_ex_en    = active && !dm_stall;
        ex_dm_en    = active && !dm_stall;
        if_id_flush = br_flush;
        id_ex_flush = br_flush || lu_stall;
        wb_valid    = active && !dm_stall;
        dm_req      = active && dm_op;
    end

    // Sequencer, wait timer, sticky error and saturating counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    wait_q <= '0;
                    if (dm_stall) begin
                        state_q <= DM_WAIT;
                    end
                end
                DM_WAIT: begin
                    if (!dm_stall) begin
                        state_q <= RUN;
                        wait_q  <= '0;
                    end else if (wait_q == WAIT_W'(DM_TIMEOUT - 1)) begin
                        state_q <= HALT;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase

            if ((dm_stall || lu_stall) && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (br_flush && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign state     = state_q;
    assign dm_err    = err_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed-vector bench for pipe_hazard_ctrl
// (DM_TIMEOUT = 4, CNT_W = 4).
// The driver applies one vector per cycle and queues its hand-computed
// expected outputs. A monitor checks each queued vector at the following
// falling edge.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CNT_W = 4;

    // Control word layout:
    //   {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    //    ex_dm_en, wb_valid, dm_req, dm_err}
    localparam logic [8:0] C_RST   = 9'b000000000;
    localparam logic [8:0] C_NORM  = 9'b110101100;
    localparam logic [8:0] C_NORMM = 9'b110101110;
    localparam logic [8:0] C_LU    = 9'b000111100;
    localparam logic [8:0] C_BR    = 9'b111111100;
    localparam logic [8:0] C_BRM   = 9'b111111110;
    localparam logic [8:0] C_DMST  = 9'b000000010;
    localparam logic [8:0] C_HALT  = 9'b000000001;

    typedef struct packed {
        int         id;
        logic [8:0] ctl;
        logic [1:0] st;
        logic [3:0] stall;
        logic [3:0] flush;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       id_rs_addr = '0;
    logic [4:0]       id_rt_addr = '0;
    logic             id_uses_rt = 1'b0;
    logic [4:0]       id_ex_rd_out_addr = '0;
    logic             id_ex_rd_ctrl = 1'b0;
    logic             ex_branch_taken = 1'b0;
    logic             ex_dm_rd_ctrl = 1'b0;
    logic             ex_dm_wd_ctrl = 1'b0;
    logic             dm_ready = 1'b0;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_dm_en;
    logic             wb_valid;
    logic             dm_req;
    logic             dm_err;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vec_id   = 0;

    pipe_hazard_ctrl #(
        .DM_TIMEOUT (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .id_rs_addr        (id_rs_addr),
        .id_rt_addr        (id_rt_addr),
        .id_uses_rt        (id_uses_rt),
        .id_ex_rd_out_addr (id_ex_rd_out_addr),
        .id_ex_rd_ctrl     (id_ex_rd_ctrl),
        .ex_branch_taken   (ex_branch_taken),
        .ex_dm_rd_ctrl     (ex_dm_rd_ctrl),
        .ex_dm_wd_ctrl     (ex_dm_wd_ctrl),
        .dm_ready          (dm_ready),
        .pc_en             (pc_en),
        .if_id_en          (if_id_en),
        .if_id_flush       (if_id_flush),
        .id_ex_en          (id_ex_en),
        .id_ex_flush       (id_ex_flush),
        .ex_dm_en          (ex_dm_en),
        .wb_valid          (wb_valid),
        .dm_req            (dm_req),
        .dm_err            (dm_err),
        .state             (state),
        .stall_cnt         (stall_cnt),
        .flush_cnt         (flush_cnt)
    );

    always #5 clk = ~clk;

    // Apply one vector just after the rising edge and queue its expectation.
    task automatic cyc(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] exrd, input logic ld,
                       input logic br, input logic drd, input logic dwr, input logic rdy,
                       input logic [8:0] ectl, input logic [1:0] est,
                       input int estall, input int eflush);
        exp_t e;
        @(posedge clk);
        #1;
        rst               = r;
        id_rs_addr        = rs;
        id_rt_addr        = rt;
        id_uses_rt        = urt;
        id_ex_rd_out_addr = exrd;
        id_ex_rd_ctrl     = ld;
        ex_branch_taken   = br;
        ex_dm_rd_ctrl     = drd;
        ex_dm_wd_ctrl     = dwr;
        dm_ready          = rdy;
        e.id    = vec_id;
        e.ctl   = ectl;
        e.st    = est;
        e.stall = 4'(estall);
        e.flush = 4'(eflush);
        q.push_back(e);
        vec_id++;
    endtask

    // Monitor: outputs are stable at the falling edge; compare against the oldest entry.
    initial begin
        exp_t       e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                       ex_dm_en, wb_valid, dm_req, dm_err};
                n_checks++;
                if (act !== e.ctl || state !== e.st ||
                    stall_cnt !== e.stall || flush_cnt !== e.flush) begin
                    n_fail++;
                    $display("FAIL vec%0d: ctl=%b st=%0d stall=%0d flush=%0d, required ctl=%b st=%0d stall=%0d flush=%0d",
                             e.id, act, state, stall_cnt, flush_cnt,
                             e.ctl, e.st, e.stall, e.flush);
                end
            end
        end
    end

    initial begin
        int budget;

        // Reset state, then normal flow.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST,  0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0, 0);

        // Load-use on rs for exactly one cycle, then release.
        cyc(0, 5, 0, 0, 5, 1, 0, 0, 0, 0, C_LU,   0, 0, 0);
        cyc(0, 5, 0, 0, 5, 0, 0, 0, 0, 0, C_NORM, 0, 1, 0);

        // Load to r0 never stalls.
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_NORM, 0, 1, 0);

        // rt hazard stalls only when rt is actually read.
        cyc(0, 3, 7, 1, 7, 1, 0, 0, 0, 0, C_LU,   0, 1, 0);
        cyc(0, 3, 7, 0, 7, 1, 0, 0, 0, 0, C_NORM, 0, 2, 0);

        // Branch flush pulse.
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_BR,   0, 2, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 2, 1);

        // Branch with load-use: flush only, no stall counted.
        cyc(0, 5, 0, 0, 5, 1, 1, 0, 0, 0, C_BR,   0, 2, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 2, 2);

        // DM read waits three cycles, then completes.
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_DMST,  0, 2, 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_DMST,  1, 3, 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_DMST,  1, 4, 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_NORMM, 1, 5, 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM,  0, 5, 2);

        // DM write ready in its first cycle costs nothing.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NORMM, 0, 5, 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM,  0, 5, 2);

        // Branch held during a 2-cycle DM stall; flushed once in the release cycle.
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, C_DMST, 0, 5, 2);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, C_DMST, 1, 6, 2);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, C_BRM,  1, 7, 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 7, 3);

        // Twenty load-use stall cycles saturate the 4-bit stall counter at 15.
        for (int i = 0; i < 20; i++) begin
            cyc(0, 9, 0, 0, 9, 1, 0, 0, 0, 0, C_LU, 0, (7 + i > 15) ? 15 : 7 + i, 3);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 15, 3);

        // Timeout: one RUN stall cycle, four DM_WAIT cycles, then HALT.
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_DMST, 0, 15, 3);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_DMST, 1, 15, 3);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_HALT, 2, 15, 3);
        // HALT absorbs even a ready memory and a branch.
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, C_HALT, 2, 15, 3);

        // Async reset clears HALT immediately.
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_RST,  0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0, 0);

        // Reset in the middle of DM_WAIT.
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_DMST, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_DMST, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_RST,  0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0, 0);

        // Let the monitor drain the queue, bounded.
        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d vectors left unchecked, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
